// File: rtl/syzygy_adc_capture.sv
// syzygy_adc_capture
//   Triggered capture buffer placed after the SYZYGY ADC front end. Once
//   armed it waits for a trigger (immediate or ch1 rising level crossing),
//   stores L paired samples {ch2, ch1} in block RAM, and then lets the host
//   logic read them back through a port with one cycle of latency.
//
// Ports
//   clk          ADC data clock; all logic runs on its rising edge
//   reset        synchronous, active-high
//   data_valid   qualifies adc_data_1 / adc_data_2 in this cycle
//   adc_data_1   channel 1 sample, two's complement
//   adc_data_2   channel 2 sample, two's complement
//   arm          single-cycle start request (accepted in IDLE or DONE)
//   trig_mode    0 = immediate, 1 = ch1 rising crossing of trig_level
//   trig_level   signed threshold used by trig_mode = 1
//   capture_len  sample pairs to store; 0 or > DEPTH means DEPTH
//   rd_en        read request (accepted only in DONE while not empty)
//   rd_data      {ch2, ch1}, valid when rd_valid is high, held otherwise
//   rd_valid     rd_data carries a new word this cycle
//   rd_empty     no unread samples
//   busy         high in ARMED or CAPTURE
//   done         high in DONE
module syzygy_adc_capture #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  data_valid,
   input  logic [15:0]           adc_data_1,
   input  logic [15:0]           adc_data_2,
   input  logic                  arm,
   input  logic                  trig_mode,
   input  logic [15:0]           trig_level,
   input  logic [DEPTH_LOG2:0]   capture_len,
   input  logic                  rd_en,
   output logic [31:0]           rd_data,
   output logic                  rd_valid,
   output logic                  rd_empty,
   output logic                  busy,
   output logic                  done
);

   localparam int                DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_W = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] ONE_W   = (DEPTH_LOG2+1)'(1);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

   state_t                state;
   logic [DEPTH_LOG2:0]   len_q;
   logic [DEPTH_LOG2:0]   wr_ptr;
   logic [DEPTH_LOG2:0]   rd_ptr;
   logic                  mode_q;
   logic signed [15:0]    level_q;
   logic signed [15:0]    hist_ch1;
   logic                  hist_vld;

   logic [31:0]           mem [DEPTH];

   logic [DEPTH_LOG2:0]   len_eff;
   logic                  trig_hit;
   logic                  wr_en;
   logic [DEPTH_LOG2-1:0] wr_addr;
   logic [DEPTH_LOG2:0]   wr_next;
   logic                  rd_fire;

   always_comb begin
      len_eff  = ((capture_len == '0) || (capture_len > DEPTH_W)) ? DEPTH_W : capture_len;
      // Compare only against registered history so the trigger sample itself
      // is written in the same cycle, with no extra pipeline stage.
      trig_hit = !mode_q ||
                 (hist_vld && (hist_ch1 < level_q) && ($signed(adc_data_1) >= level_q));
      wr_en    = !reset && data_valid &&
                 (((state == S_ARMED) && trig_hit) || (state == S_CAPTURE));
      // The triggering sample always lands at address 0.
      wr_addr  = (state == S_ARMED) ? '0 : wr_ptr[DEPTH_LOG2-1:0];
      wr_next  = (state == S_ARMED) ? ONE_W : wr_ptr + ONE_W;
      rd_empty = !((state == S_DONE) && (rd_ptr != len_q));
      // arm in DONE restarts; a read in that same cycle is dropped.
      rd_fire  = (state == S_DONE) && rd_en && !rd_empty && !arm;
      busy     = (state == S_ARMED) || (state == S_CAPTURE);
      done     = (state == S_DONE);
   end

   // RAM write port kept free of reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= {adc_data_2, adc_data_1};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         len_q    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mode_q   <= 1'b0;
         level_q  <= '0;
         hist_ch1 <= '0;
         hist_vld <= 1'b0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_fire;
         if (rd_fire) begin
            rd_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            rd_ptr  <= rd_ptr + ONE_W;
         end
         case (state)
            S_IDLE, S_DONE: begin
               if (arm) begin
                  state    <= S_ARMED;
                  mode_q   <= trig_mode;
                  level_q  <= trig_level;
                  len_q    <= len_eff;
                  wr_ptr   <= '0;
                  rd_ptr   <= '0;
                  hist_vld <= 1'b0;
               end
            end
            S_ARMED: begin
               if (data_valid) begin
                  hist_vld <= 1'b1;
                  hist_ch1 <= adc_data_1;
                  if (trig_hit) begin
                     wr_ptr <= wr_next;
                     state  <= (wr_next == len_q) ? S_DONE : S_CAPTURE;
                  end
               end
            end
            S_CAPTURE: begin
               if (data_valid) begin
                  wr_ptr <= wr_next;
                  if (wr_next == len_q) state <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
